// File: rtl/breakout_game_ctrl_pkg.sv
// Shared definitions for the Breakout game sequencer: state codes used by the
// controller and by the display/score logic, plus default game sizing.
package game_pkg;

  localparam logic [2:0] STATE_IDLE   = 3'd0;
  localparam logic [2:0] STATE_SERVE  = 3'd1;
  localparam logic [2:0] STATE_PLAY   = 3'd2;
  localparam logic [2:0] STATE_PAUSED = 3'd3;
  localparam logic [2:0] STATE_LOST   = 3'd4;
  localparam logic [2:0] STATE_OVER   = 3'd5;
  localparam logic [2:0] STATE_WIN    = 3'd6;

  localparam int unsigned LIVES_INIT_DEF = 3;
  localparam int unsigned NUM_BRICKS_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = STATE_IDLE,
    ST_SERVE  = STATE_SERVE,
    ST_PLAY   = STATE_PLAY,
    ST_PAUSED = STATE_PAUSED,
    ST_LOST   = STATE_LOST,
    ST_OVER   = STATE_OVER,
    ST_WIN    = STATE_WIN
  } state_e;

endpackage

// File: rtl/breakout_game_ctrl_frame_timer.sv
// Frame-tick counter shared by the serve and life-lost freezes; done fires on
// the tick whose count equals last_i, and the counter then returns to zero.
module frame_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         start_i,
  input  logic         tick_i,
  input  logic [W-1:0] last_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign done_o = en_i && tick_i && (cnt_q == last_i);

  always_comb begin
    cnt_d = cnt_q;
    if (start_i || done_o) begin
      cnt_d = '0;
    end else if (en_i && tick_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout round sequencer: serve/play/pause/lost/over/win life-cycle, lives
// and brick bookkeeping, and the field/ball reload pulses for the pixel path.
module breakout_game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT   = LIVES_INIT_DEF,
  parameter int unsigned NUM_BRICKS   = NUM_BRICKS_DEF,
  parameter int unsigned SERVE_FRAMES = 120,
  parameter int unsigned LOST_FRAMES  = 60,
  localparam int unsigned BW = $clog2(NUM_BRICKS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          refresh_tick,
  input  logic          btn_start,
  input  logic          btn_pause,
  input  logic          collision,
  input  logic          ball_lost,
  output logic          pause,
  output logic          field_reset,
  output logic          ball_respawn,
  output logic [2:0]    state,
  output logic [1:0]    lives,
  output logic [BW-1:0] bricks_left
);

  localparam int unsigned FRAMES_MAX = (SERVE_FRAMES > LOST_FRAMES) ? SERVE_FRAMES : LOST_FRAMES;
  localparam int unsigned CW         = (FRAMES_MAX > 1) ? $clog2(FRAMES_MAX) : 1;
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] LOST_LAST  = CW'(LOST_FRAMES - 1);
  localparam logic [1:0]    LIVES_LD   = 2'(LIVES_INIT);
  localparam logic [BW-1:0] BRICKS_LD  = BW'(NUM_BRICKS);

  state_e        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [BW-1:0] bricks_q, bricks_d;
  logic          field_reset_q, field_reset_d;
  logic          ball_respawn_q, ball_respawn_d;
  logic          tmr_start, tmr_done, tmr_en;
  logic [BW-1:0] bricks_hit;

  assign tmr_en = (state_q == ST_SERVE) || (state_q == ST_LOST);

  frame_timer #(.W(CW)) u_frame_timer (
    .clk     (clk),
    .reset   (reset),
    .en_i    (tmr_en),
    .start_i (tmr_start),
    .tick_i  (refresh_tick),
    .last_i  ((state_q == ST_SERVE) ? SERVE_LAST : LOST_LAST),
    .done_o  (tmr_done)
  );

  // Brick count after a collision in this cycle, saturating at zero.
  assign bricks_hit = (collision && bricks_q != '0) ? bricks_q - 1'b1 : bricks_q;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    bricks_d       = bricks_q;
    field_reset_d  = 1'b0;
    ball_respawn_d = 1'b0;
    tmr_start      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_OVER, ST_WIN: begin
        if (btn_start) begin
          state_d       = ST_SERVE;
          field_reset_d = 1'b1;
          lives_d       = LIVES_LD;
          bricks_d      = BRICKS_LD;
          tmr_start     = 1'b1;
        end
      end
      ST_SERVE: begin
        if (tmr_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (collision && bricks_q == BW'(1)) begin
          state_d  = ST_WIN;
          bricks_d = '0;
        end else if (refresh_tick && ball_lost) begin
          state_d   = ST_LOST;
          lives_d   = (lives_q != 2'd0) ? lives_q - 2'd1 : lives_q;
          bricks_d  = bricks_hit;
          tmr_start = 1'b1;
        end else if (btn_pause) begin
          state_d  = ST_PAUSED;
          bricks_d = bricks_hit;
        end else begin
          bricks_d = bricks_hit;
        end
      end
      ST_PAUSED: begin
        if (btn_pause) state_d = ST_PLAY;
      end
      ST_LOST: begin
        if (tmr_done) begin
          if (lives_q == 2'd0) begin
            state_d = ST_OVER;
          end else begin
            state_d        = ST_SERVE;
            ball_respawn_d = 1'b1;
            tmr_start      = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      lives_q        <= LIVES_LD;
      bricks_q       <= BRICKS_LD;
      field_reset_q  <= 1'b0;
      ball_respawn_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      bricks_q       <= bricks_d;
      field_reset_q  <= field_reset_d;
      ball_respawn_q <= ball_respawn_d;
    end
  end

  assign pause        = (state_q != ST_PLAY);
  assign field_reset  = field_reset_q;
  assign ball_respawn = ball_respawn_q;
  assign state        = state_q;
  assign lives        = lives_q;
  assign bricks_left  = bricks_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for breakout_game_ctrl: walks a full game (serve, pause,
// lost balls, game over, win) and a mid-round reset against hand-computed values.
module tb_breakout_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refresh_tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       collision = 1'b0;
  logic       ball_lost = 1'b0;
  logic       pause;
  logic       field_reset;
  logic       ball_respawn;
  logic [2:0] state;
  logic [1:0] lives;
  logic [2:0] bricks_left;

  int total = 0;
  int bad   = 0;

  breakout_game_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .btn_start    (btn_start),
    .btn_pause    (btn_pause),
    .collision    (collision),
    .ball_lost    (ball_lost),
    .pause        (pause),
    .field_reset  (field_reset),
    .ball_respawn (ball_respawn),
    .state        (state),
    .lives        (lives),
    .bricks_left  (bricks_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic st, input logic pa, input logic co,
                       input logic tk, input logic bl);
    btn_start    = st;
    btn_pause    = pa;
    collision    = co;
    refresh_tick = tk;
    ball_lost    = bl;
    cycle();
    btn_start    = 1'b0;
    btn_pause    = 1'b0;
    collision    = 1'b0;
    refresh_tick = 1'b0;
    ball_lost    = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    cycle();
    cycle();
    check("rst_state",  state, 0);
    check("rst_pause",  pause, 1);
    check("rst_fr",     field_reset, 0);
    check("rst_resp",   ball_respawn, 0);
    check("rst_lives",  lives, 3);
    check("rst_bricks", bricks_left, 6);
    reset = 1'b0;
    cycle();
    check("idle_hold", state, 0);

    // Start a game
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("start_state", state, 1);
    check("start_fr",    field_reset, 1);
    check("start_pause", pause, 1);
    pulse(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("fr_one_cycle",    field_reset, 0);
    check("serve_ign_col",   bricks_left, 6);
    check("serve_ign_lost",  lives, 3);
    check("serve_ign_state", state, 1);
    ticks(118);
    check("serve_119", state, 1);
    ticks(1);
    check("serve_120_state", state, 2);
    check("serve_120_pause", pause, 0);

    // Pause together with a collision
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pause_state",  state, 3);
    check("pause_bricks", bricks_left, 5);
    check("pause_out",    pause, 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("paused_ign_col",   bricks_left, 5);
    check("paused_ign_lives", lives, 3);
    check("paused_ign_state", state, 3);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("resume_state", state, 2);
    check("resume_pause", pause, 0);

    // Ball lost with simultaneous collision
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("lost1_state",  state, 4);
    check("lost1_lives",  lives, 2);
    check("lost1_bricks", bricks_left, 4);
    ticks(59);
    check("lost1_59", state, 4);
    ticks(1);
    check("lost1_end_state",  state, 1);
    check("lost1_respawn",    ball_respawn, 1);
    check("lost1_no_fr",      field_reset, 0);
    check("lost1_keep_brick", bricks_left, 4);
    cycle();
    check("respawn_one_cycle", ball_respawn, 0);
    ticks(120);
    check("serve2_play", state, 2);

    // Ball lost without a tick has no effect
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lost_needs_tick", state, 2);

    // Lose remaining two lives -> game over
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("lost2_lives", lives, 1);
    ticks(60);
    ticks(120);
    check("serve3_play", state, 2);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("lost3_state", state, 4);
    check("lost3_lives", lives, 0);
    ticks(60);
    check("over_state",   state, 5);
    check("over_pause",   pause, 1);
    check("over_respawn", ball_respawn, 0);
    check("over_lives",   lives, 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("over_ign_col", bricks_left, 4);

    // Restart from game over
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_state",  state, 1);
    check("restart_fr",     field_reset, 1);
    check("restart_lives",  lives, 3);
    check("restart_bricks", bricks_left, 6);
    ticks(120);
    check("restart_play", state, 2);

    // Clear all six bricks -> win
    for (int i = 1; i <= 5; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("col%0d_bricks", i), bricks_left, 6 - i);
    end
    check("col5_state", state, 2);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("win_bricks", bricks_left, 0);
    check("win_state",  state, 6);
    check("win_pause",  pause, 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("win_sat_bricks", bricks_left, 0);
    check("win_sat_state",  state, 6);

    // Restart from win, then reset in the middle of a LOST freeze
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("win_restart_state",  state, 1);
    check("win_restart_fr",     field_reset, 1);
    check("win_restart_bricks", bricks_left, 6);
    ticks(120);
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("lost4_state", state, 4);
    ticks(30);
    reset = 1'b1;
    #1;
    check("rst_async_state", state, 0);
    cycle();
    check("midrst_state",   state, 0);
    check("midrst_pause",   pause, 1);
    check("midrst_lives",   lives, 3);
    check("midrst_bricks",  bricks_left, 6);
    check("midrst_fr",      field_reset, 0);
    check("midrst_respawn", ball_respawn, 0);
    reset = 1'b0;
    cycle();
    check("post_rst_idle", state, 0);
    check("post_rst_fr",   field_reset, 0);

    // Frame counter restarted from zero after reset
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_serve", state, 1);
    ticks(119);
    check("post_rst_119", state, 1);
    ticks(1);
    check("post_rst_play", state, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed sequence is a few thousand cycles at most.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
